// File: rtl/mcu_sequencer.sv
// Program sequencer for the 20-bit-instruction MCU core: PC, return-address stack, wait timer.
// Optional build macro MCU_SEQ_STACK_GUARD_EN traps stack overflow/underflow into a sticky ERR state.
module mcu_sequencer #(
  parameter int unsigned PC_W        = 16,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  output logic [PC_W-1:0]              imem_addr,
  output logic                         imem_en,
  input  logic                         jmp_en,
  input  logic [15:0]                  jmp_const,
  input  logic                         call_en,
  input  logic [15:0]                  call_const,
  input  logic                         return_en,
  input  logic                         wait_en,
  input  logic                         wait_med,
  input  logic [1:0]                   wait_unit,
  input  logic [7:0]                   wait_const,
  input  logic                         trig,
  output logic                         exec_en,
  output logic                         busy,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  localparam int unsigned SP_IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W     = SP_IDX_W + 1;
  localparam int unsigned CNT_W    = 20;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2
`ifdef MCU_SEQ_STACK_GUARD_EN
    , ST_ERR = 2'd3
`endif
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     stack_top;
  logic [PC_W-1:0]     stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    wait_load;
  logic                wait_trig_mode;
  logic [SP_W-1:0]     sp_inc;
  logic [SP_W-1:0]     sp_dec;
  logic                in_exec;
  logic                in_wait;
  logic                do_jmp;
  logic                do_call;
  logic                do_ret;
  logic                do_wait;
  logic                wait_start;
  logic                do_step;
  logic                wait_done;
  logic                stack_full;
  logic                stack_empty;
  logic                push;
  logic                pop;

  // Strobe decode with fixed priority in case the decoder ever asserts more than one.
  assign in_exec    = (state == ST_EXEC);
  assign in_wait    = (state == ST_WAIT);
  assign do_jmp     = in_exec & jmp_en;
  assign do_call    = in_exec & ~jmp_en & call_en;
  assign do_ret     = in_exec & ~jmp_en & ~call_en & return_en;
  assign do_wait    = in_exec & ~jmp_en & ~call_en & ~return_en & wait_en;
  assign wait_start = do_wait & (wait_const != 8'd0);
  assign do_step    = in_exec & ~jmp_en & ~call_en & ~return_en & ~wait_start;

  assign pc_inc     = pc + PC_W'(1);
  assign imem_addr  = pc;

  // Timed waits count N*U-1 down to zero; trigger waits count N trig cycles.
  assign wait_load  = wait_med ? CNT_W'(wait_const)
                               : (CNT_W'(wait_const) << {wait_unit, 2'b00}) - CNT_W'(1);
  assign wait_done  = wait_trig_mode ? (trig && (wait_cnt == CNT_W'(1)))
                                     : (wait_cnt == '0);

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign sp_inc      = stack_full  ? SP_W'(1) : sp + SP_W'(1);
  assign sp_dec      = stack_empty ? SP_W'(STACK_DEPTH - 1) : sp - SP_W'(1);
  assign stack_top   = stack_mem[SP_IDX_W'(sp - SP_W'(1))];

`ifdef MCU_SEQ_STACK_GUARD_EN
  logic stack_err;

  assign push      = do_call & ~stack_full;
  assign pop       = do_ret & ~stack_empty;
  assign stack_err = (do_call & stack_full) | (do_ret & stack_empty);

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (do_call && stack_full) stack_ovf <= 1'b1;
      if (do_ret && stack_empty) stack_unf <= 1'b1;
    end
  end
`else
  // Unguarded stack: pointer wraps, oldest entry overwritten or stale entry read.
  assign push      = do_call;
  assign pop       = do_ret;
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (run) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = wait_start ? ST_WAIT : ST_FETCH;
`ifdef MCU_SEQ_STACK_GUARD_EN
        if (stack_err) state_next = ST_ERR;
`endif
      end
      ST_WAIT: begin
        if (wait_done) state_next = ST_FETCH;
      end
`ifdef MCU_SEQ_STACK_GUARD_EN
      ST_ERR: begin
        state_next = ST_ERR;
      end
`endif
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Combinational outputs decoded from state.
  always_comb begin
    imem_en = 1'b0;
    exec_en = 1'b0;
    busy    = 1'b0;
    case (state)
      ST_FETCH: imem_en = run;
      ST_EXEC:  exec_en = ~(jmp_en | call_en | return_en | wait_en);
      ST_WAIT:  busy    = 1'b1;
      default: begin
        imem_en = 1'b0;
      end
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_W'(RESET_PC);
    end else if (do_jmp) begin
      pc <= PC_W'(jmp_const);
    end else if (push) begin
      pc <= PC_W'(call_const);
    end else if (pop) begin
      pc <= stack_top;
    end else if (do_step || (in_wait && wait_done)) begin
      pc <= pc_inc;
    end
  end

  // Stack pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp_inc;
    end else if (pop) begin
      sp <= sp_dec;
    end
  end

  // Return-address storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) stack_mem[SP_IDX_W'(sp)] <= pc_inc;
  end

  // Wait counter and mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt       <= '0;
      wait_trig_mode <= 1'b0;
    end else if (wait_start) begin
      wait_cnt       <= wait_load;
      wait_trig_mode <= wait_med;
    end else if (in_wait) begin
      if (wait_done)                  wait_cnt <= '0;
      else if (!wait_trig_mode || trig) wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: program-level reference model driven by a
// bench-side synchronous instruction memory, directed scenarios plus a random program.
module tb_mcu_sequencer;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned DEPTH = 8;

  localparam int OP_SET  = 0;
  localparam int OP_JMP  = 1;
  localparam int OP_CALL = 2;
  localparam int OP_RET  = 3;
  localparam int OP_WAIT = 4;

  typedef struct {
    int         op;
    logic [15:0] c;
    logic        med;
    logic [1:0]  unit;
    logic [7:0]  n;
  } instr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_en;
  logic             jmp_en = 1'b0;
  logic [15:0]      jmp_const = '0;
  logic             call_en = 1'b0;
  logic [15:0]      call_const = '0;
  logic             return_en = 1'b0;
  logic             wait_en = 1'b0;
  logic             wait_med = 1'b0;
  logic [1:0]       wait_unit = '0;
  logic [7:0]       wait_const = '0;
  logic             trig = 1'b0;
  logic             exec_en;
  logic             busy;
  logic [3:0]       sp;
  logic             stack_ovf;
  logic             stack_unf;

  instr_t      prog [4096];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mem_pend = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_stk [$];
  bit          directed = 1'b1;

  always #5 clk = ~clk;

  mcu_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_en(imem_en),
    .jmp_en(jmp_en), .jmp_const(jmp_const),
    .call_en(call_en), .call_const(call_const),
    .return_en(return_en), .wait_en(wait_en),
    .wait_med(wait_med), .wait_unit(wait_unit), .wait_const(wait_const),
    .trig(trig), .exec_en(exec_en), .busy(busy), .sp(sp),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decoder outputs; fields not used by the opcode carry random junk.
  task automatic drive_strobes(input instr_t ins);
    jmp_en     = (ins.op == OP_JMP);
    call_en    = (ins.op == OP_CALL);
    return_en  = (ins.op == OP_RET);
    wait_en    = (ins.op == OP_WAIT);
    jmp_const  = (ins.op == OP_JMP)  ? ins.c : 16'($urandom);
    call_const = (ins.op == OP_CALL) ? ins.c : 16'($urandom);
    wait_med   = (ins.op == OP_WAIT) ? ins.med  : 1'($urandom);
    wait_unit  = (ins.op == OP_WAIT) ? ins.unit : 2'($urandom);
    wait_const = (ins.op == OP_WAIT) ? ins.n    : 8'($urandom);
  endtask

  task automatic clear_strobes();
    jmp_en = 1'b0; call_en = 1'b0; return_en = 1'b0; wait_en = 1'b0;
    jmp_const = '0; call_const = '0; wait_med = 1'b0; wait_unit = '0; wait_const = '0;
  endtask

  // One clock cycle: apply inputs, check outputs, then advance past the next rising edge.
  task automatic cyc(input logic [15:0] e_addr, input bit e_en, input bit e_exec,
                     input bit e_busy, input int e_sp, input bit r, input bit t);
    if (mem_pend) begin
      drive_strobes(prog[mem_addr[11:0]]);
      mem_pend = 1'b0;
    end
    run  = r;
    trig = t;
    #1;
    check("imem_addr", 32'(imem_addr), 32'(e_addr));
    check("imem_en",   32'(imem_en),   32'(e_en));
    check("exec_en",   32'(exec_en),   32'(e_exec));
    check("busy",      32'(busy),      32'(e_busy));
    check("sp",        32'(sp),        32'(e_sp));
    if (imem_en) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit get_trig(input int k);
    if (directed) return (k == 3) || (k == 7);
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rnd_bit();
    if (directed) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    run = 1'b0;
    trig = 1'b0;
    clear_strobes();
    mem_pend = 1'b0;
    m_pc = '0;
    m_stk.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_addr",  32'(imem_addr), 32'h0);
    check("rst_en",    32'(imem_en),   32'h0);
    check("rst_exec",  32'(exec_en),   32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_sp",    32'(sp),        32'h0);
    check("rst_ovf",   32'(stack_ovf), 32'h0);
    check("rst_unf",   32'(stack_unf), 32'h0);
    rst = 1'b0;
  endtask

  // Reference model: one instruction = FETCH, EXEC, then any wait cycles.
  task automatic run_instr();
    instr_t ins;
    int     idx;
    int     cnt;
    int     k;
    bit     t;
    idx = int'(m_pc[11:0]);
    if (!directed) begin
      if (prog[idx].op == OP_RET && m_stk.size() == 0) prog[idx].op = OP_SET;
      if (prog[idx].op == OP_CALL && m_stk.size() == int'(DEPTH)) prog[idx].op = OP_SET;
      if ($urandom_range(0, 7) == 0) cyc(m_pc, 1'b0, 1'b0, 1'b0, m_stk.size(), 1'b0, rnd_bit());
    end
    cyc(m_pc, 1'b1, 1'b0, 1'b0, m_stk.size(), 1'b1, directed ? 1'b0 : rnd_bit());
    ins = prog[idx];
    cyc(m_pc, 1'b0, ins.op == OP_SET, 1'b0, m_stk.size(), rnd_bit(), get_trig(0));
    case (ins.op)
      OP_JMP:  m_pc = ins.c;
      OP_CALL: begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = ins.c;
      end
      OP_RET:  m_pc = m_stk.pop_back();
      OP_WAIT: begin
        if (ins.n == 8'd0) begin
          m_pc = m_pc + 16'd1;
        end else if (!ins.med) begin
          repeat (int'(ins.n) << (4 * int'(ins.unit)))
            cyc(m_pc, 1'b0, 1'b0, 1'b1, m_stk.size(), rnd_bit(), 1'($urandom_range(0, 1)));
          m_pc = m_pc + 16'd1;
        end else begin
          cnt = 0;
          k = 1;
          while (cnt < int'(ins.n)) begin
            t = get_trig(k);
            cyc(m_pc, 1'b0, 1'b0, 1'b1, m_stk.size(), rnd_bit(), t);
            if (t) cnt++;
            k++;
          end
          m_pc = m_pc + 16'd1;
        end
      end
      default: m_pc = m_pc + 16'd1;
    endcase
  endtask

  task automatic set_instr(input int addr, input int op, input logic [15:0] c,
                           input bit med, input logic [1:0] unit, input logic [7:0] n);
    prog[addr[11:0]].op   = op;
    prog[addr[11:0]].c    = c;
    prog[addr[11:0]].med  = med;
    prog[addr[11:0]].unit = unit;
    prog[addr[11:0]].n    = n;
  endtask

  task automatic fill_random();
    int r;
    for (int i = 0; i < 4096; i++) begin
      r = int'($urandom_range(0, 99));
      prog[i].op   = (r < 50) ? OP_SET : (r < 60) ? OP_JMP : (r < 72) ? OP_CALL :
                     (r < 84) ? OP_RET : OP_WAIT;
      prog[i].c    = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      prog[i].med  = 1'($urandom_range(0, 1));
      prog[i].unit = 2'($urandom_range(0, 3));
      if (prog[i].med)           prog[i].n = 8'($urandom_range(0, 5));
      else if (prog[i].unit > 1) prog[i].n = 8'($urandom_range(0, 1));
      else                       prog[i].n = 8'($urandom_range(0, 12));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) set_instr(i, OP_SET, 16'h0, 1'b0, 2'd0, 8'd0);

    // Directed program: straight line, JMP, CALL/RET, timed wait, NOP wait, trigger wait, PC wrap.
    set_instr(16'h0005, OP_JMP,  16'h0010, 1'b0, 2'd0, 8'd0);
    set_instr(16'h0010, OP_CALL, 16'h0100, 1'b0, 2'd0, 8'd0);
    set_instr(16'h0100, OP_RET,  16'h0000, 1'b0, 2'd0, 8'd0);
    set_instr(16'h0011, OP_WAIT, 16'h0000, 1'b0, 2'd1, 8'd3);
    set_instr(16'h0012, OP_WAIT, 16'h0000, 1'b0, 2'd2, 8'd0);
    set_instr(16'h0013, OP_WAIT, 16'h0000, 1'b1, 2'd0, 8'd2);
    set_instr(16'h0014, OP_JMP,  16'hFFFF, 1'b0, 2'd0, 8'd0);
    directed = 1'b1;
    do_reset();
    repeat (15) run_instr();

    // Nested CALL chain past the stack depth.
    do_reset();
    for (int i = 0; i < 9; i++) set_instr(i, OP_CALL, 16'(i + 1), 1'b0, 2'd0, 8'd0);
    set_instr(9, OP_SET, 16'h0, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      cyc(16'(i), 1'b1, 1'b0, 1'b0, i, 1'b1, 1'b0);
      cyc(16'(i), 1'b0, 1'b0, 1'b0, i, 1'b1, 1'b0);
    end
`ifdef MCU_SEQ_STACK_GUARD_EN
    repeat (4) begin
      check("ovf_flag", 32'(stack_ovf), 32'h1);
      check("ovf_unf",  32'(stack_unf), 32'h0);
      cyc(16'h0008, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0);
    end
`else
    cyc(16'h0009, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    cyc(16'h0009, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    check("ovf_tied", 32'(stack_ovf), 32'h0);
`endif

    // Asynchronous reset in the middle of a trigger wait.
    do_reset();
    set_instr(16'h0000, OP_JMP,  16'h0030, 1'b0, 2'd0, 8'd0);
    set_instr(16'h0030, OP_CALL, 16'h0050, 1'b0, 2'd0, 8'd0);
    set_instr(16'h0050, OP_WAIT, 16'h0000, 1'b1, 2'd0, 8'd200);
    run_instr();
    run_instr();
    cyc(16'h0050, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    cyc(16'h0050, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (5) cyc(16'h0050, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_addr", 32'(imem_addr), 32'h0);
    check("midrst_busy", 32'(busy),      32'h0);
    check("midrst_sp",   32'(sp),        32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_strobes();
    mem_pend = 1'b0;
    m_pc = '0;
    m_stk.delete();
    run_instr();
    run_instr();

    // Random program with random run/trig activity.
    fill_random();
    directed = 1'b0;
    do_reset();
    repeat (400) run_instr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
